// File: rtl/l1a_lct_match_n.sv
// Multi-channel LCT/L1A coincidence matcher with programmable latency/window,
// optional LCT consumption, and saturating L1A / no-match counters.
module l1a_lct_match_n #(
    parameter int NCH   = 7,
    parameter int LAT_W = 6,
    parameter int WIN_W = 4,
    parameter int TMR   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NCH-1:0]   LCT,
    input  logic             L1A,
    input  logic [LAT_W-1:0] LATENCY,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic [NCH-1:0]   KILL,
    input  logic             CONSUME,
    input  logic             CNT_CLR,
    output logic [NCH-1:0]   L1A_MATCH,
    output logic             L1A_OUT,
    output logic             NOMATCH,
    output logic [15:0]      L1A_CNT,
    output logic [15:0]      NOMATCH_CNT
);

    localparam int DEPTH = 2**LAT_W + 2**WIN_W;
    localparam int SW    = NCH*DEPTH + NCH + 2 + 32;

    logic [NCH-1:0][DEPTH-1:0] hist_q;
    logic [NCH-1:0][DEPTH-1:0] hist_d;
    logic [NCH-1:0][DEPTH:0]   hist_x;
    logic [DEPTH:0]            wmask;
    logic [WIN_W-1:0]          win_eff;
    int                        lo;
    int                        hi;
    logic [NCH-1:0]            match_d;
    logic                      nomatch_d;
    logic [15:0]               l1a_cnt_d;
    logic [15:0]               nm_cnt_d;
    logic [SW-1:0]             state_d;
    logic [SW-1:0]             state_q;

    // Window spans [LATENCY, LATENCY+W-1] in "BX ago" units; index 0 is the live LCT input.
    always_comb begin
        win_eff = (WINDOW == '0) ? WIN_W'(1) : WINDOW;
        lo      = {{(32-LAT_W){1'b0}}, LATENCY};
        hi      = lo + {{(32-WIN_W){1'b0}}, win_eff};
        wmask   = '0;
        for (int k = 0; k <= DEPTH; k++) begin
            wmask[k] = (k >= lo) && (k < hi);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign hist_x[c]  = {hist_q[c], LCT[c]};
        assign match_d[c] = L1A & ~KILL[c] & (|(hist_x[c] & wmask));
        // Consumed bits are cleared before the shift so they travel onward as zeros.
        assign hist_d[c]  = (match_d[c] & CONSUME) ? hist_x[c][DEPTH-1:0] & ~wmask[DEPTH-1:0]
                                                   : hist_x[c][DEPTH-1:0];
    end

    assign nomatch_d = L1A & ~(|match_d);

    always_comb begin
        l1a_cnt_d = L1A_CNT;
        nm_cnt_d  = NOMATCH_CNT;
        if (CNT_CLR) begin
            l1a_cnt_d = '0;
            nm_cnt_d  = '0;
        end else begin
            if (L1A && (L1A_CNT != 16'hFFFF)) begin
                l1a_cnt_d = L1A_CNT + 16'd1;
            end
            if (nomatch_d && (NOMATCH_CNT != 16'hFFFF)) begin
                nm_cnt_d = NOMATCH_CNT + 16'd1;
            end
        end
    end

    assign state_d = {hist_d, match_d, L1A, nomatch_d, l1a_cnt_d, nm_cnt_d};
    assign {hist_q, L1A_MATCH, L1A_OUT, NOMATCH, L1A_CNT, NOMATCH_CNT} = state_q;

    if (TMR != 0) begin : g_tmr
        logic [SW-1:0] r0_q;
        logic [SW-1:0] r1_q;
        logic [SW-1:0] r2_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r0_q <= '0;
                r1_q <= '0;
                r2_q <= '0;
            end else begin
                r0_q <= state_d;
                r1_q <= state_d;
                r2_q <= state_d;
            end
        end

        // Bitwise majority; next state is built from the voted value so an upset is scrubbed.
        assign state_q = (r0_q & r1_q) | (r0_q & r2_q) | (r1_q & r2_q);
    end else begin : g_plain
        logic [SW-1:0] r_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_q <= '0;
            end else begin
                r_q <= state_d;
            end
        end

        assign state_q = r_q;
    end

endmodule

// File: doc/l1a_lct_match_n.md
Name: l1a_lct_match_n

Overview:
Parametrised, multi-channel successor to the fixed 5-CFEB LCT/L1A matcher inside trgcntrl. The block keeps a per-channel history of LCT strobes. On each L1A it checks whether each channel saw an LCT inside a programmable window placed LATENCY bunch crossings earlier, and issues per-channel L1A_MATCH pulses. New features over the fixed block: a configurable window width, an optional consume mode (one LCT answers at most one L1A), and saturating L1A and no-match counters. It sits between the trigger inputs (RAWLCT/L1ACC) and the L1M_LCT output registers, clocked by clkcms.

Parameters:
NCH, 7, number of front-end channels (bit 0 = channel 1).
LAT_W, 6, latency field width; history depth DEPTH = 2**LAT_W + 2**WIN_W.
WIN_W, 4, window-width field width.
TMR, 0, triple-modular redundancy of state registers (1 = triplicate with majority vote; no functional change).

Ports:
CLK  in  1  clkcms, all logic on rising edge.
RST  in  1  asynchronous, active-high reset.
LCT  in  NCH  per-channel LCT strobe, one bit per BX.
L1A  in  1  level-1 accept strobe.
LATENCY  in  LAT_W  L1A-to-LCT latency in BX.
WINDOW  in  WIN_W  window width in BX; 0 is treated as 1.
KILL  in  NCH  per-channel mask; 1 = channel never matches.
CONSUME  in  1  0 = share mode, 1 = consume mode.
CNT_CLR  in  1  synchronous clear of both counters.
L1A_MATCH  out  NCH  registered per-channel match pulse.
L1A_OUT  out  1  L1A delayed by one clock, aligned with L1A_MATCH.
NOMATCH  out  1  one-clock pulse: L1A with zero matched channels.
L1A_CNT  out  16  saturating count of L1As.
NOMATCH_CNT  out  16  saturating count of no-match L1As.

Behaviour:
- History: per channel, a DEPTH-bit shift register h. Each cycle h[0] <= LCT[c] and h[k] <= h[k-1], so h[k] holds LCT from k cycles ago.
- Window: W = max(WINDOW,1). Channel c is in-window at cycle t if any h[k] is set for k in [LATENCY, LATENCY+W-1]. Because DEPTH covers the maximum of LATENCY+W-1, no clamping is needed.
- Match at cycle t: m[c] = L1A & ~KILL[c] & in-window[c]. Registered, so L1A_MATCH = m and L1A_OUT = L1A appear at t+1. Each output is high for exactly one cycle per L1A.
- NOMATCH at t+1 = L1A(t) & (m == 0).
- Consume mode (CONSUME=1): when m[c]=1, all history bits of channel c in the window range are cleared. The clear takes effect in the same shift as the cycle-t update; the cleared bits shift onward as 0.
- Consume with back-to-back L1As at t and t+1: the second L1A cannot reuse the LCT consumed by the first. It matches only if another LCT lies in its own window.
- Share mode (CONSUME=0): the history is never modified by matches.
- L1A with an LCT in the same cycle: that LCT enters h[0] and is eligible only when LATENCY = 0.
- Config changes: LATENCY, WINDOW, KILL and CONSUME are sampled every cycle. A change affects the next L1A evaluated; the history is not flushed.
- Counters:
  - L1A_CNT increments on each L1A and saturates at 16'hFFFF.
  - NOMATCH_CNT increments together with NOMATCH (same cycle as the pulse) and saturates at 16'hFFFF.
  - CNT_CLR has priority over an increment in the same cycle: the counter goes to 0.
- Reset (async assert, released on a clock edge): all history bits, L1A_MATCH, L1A_OUT, NOMATCH, L1A_CNT and NOMATCH_CNT go to 0. An L1A in flight during reset is lost, with no pulse after release.
- With TMR=1: every history bit, output register and counter bit is triplicated and voted. Single upsets in one copy must not change the outputs.

Test Plan:
- LATENCY=10, WINDOW=1, share: LCT[2] at t0, L1A at t0+10 -> L1A_MATCH=7'b0000100 and L1A_OUT=1 at t0+11 only. L1A at t0+9 instead -> NOMATCH=1, NOMATCH_CNT=1.
- LATENCY=10, WINDOW=4: LCT[0] at t0, L1As at t0+9, t0+10, t0+13, t0+14 (separate runs) -> match only at t0+10 and t0+13.
- Consume vs share: LATENCY=5, WINDOW=3, LCT[4] at t0, L1A at t0+5 and t0+6. CONSUME=1 -> first L1A matches, second gives NOMATCH. CONSUME=0 -> both match bit 4.
- KILL=7'h7F with LCTs on all channels in-window -> L1A_MATCH=0, NOMATCH=1. KILL=7'h01 -> L1A_MATCH=7'h7E.
- Counters: preload by 65535 L1As, then 2 more -> L1A_CNT stays 16'hFFFF. CNT_CLR together with L1A -> 0 next cycle.
- Assert RST while an L1A match is pending and 20 LCTs are in history -> all outputs 0. After release, L1A with LATENCY=0..20 -> NOMATCH, no stale match.
